// File: rtl/tile_buffer_in_if.sv
// Tile buffer handshake bundle: beat input stream from the input buffer and
// the whole-tile output toward the consumer.
interface tile_buffer_in_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic                   in_valid;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   in_ready;
  logic                   tile_valid;
  logic                   tile_ready;
  logic [16*DATA_W-1:0]   tile_data;

  modport master (
    output in_valid, mem_rdata, tile_ready,
    input  in_ready, tile_valid, tile_data
  );

  modport slave (
    input  in_valid, mem_rdata, tile_ready,
    output in_ready, tile_valid, tile_data
  );
endinterface

// File: rtl/tile_buffer_in.sv
// Ping-pong 4x4 tile assembler: collects 16 beats per bank, presents a full
// bank as one wide tile, and drops (and flags) beats while the write bank is full.
module tile_buffer_in #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  tile_buffer_in_if.slave     bus,
  output logic [3:0]          beat_cnt,
  output logic                overflow
);
  localparam int unsigned TILE_N = 16;

  logic [DATA_W-1:0] bank_mem [2][TILE_N];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic              accept;
  logic              drain;

  assign bus.in_ready   = ~full[wr_bank];
  assign bus.tile_valid = full[rd_bank];
  assign accept         = bus.in_valid & bus.in_ready;
  assign drain          = bus.tile_valid & bus.tile_ready;

  always_comb begin
    bus.tile_data = '0;
    for (int unsigned e = 0; e < TILE_N; e++) begin
      bus.tile_data[e*DATA_W +: DATA_W] = bank_mem[rd_bank][e[3:0]];
    end
  end

  // Completion only touches a non-full bank and drain only a full one, so the
  // two per-bit updates of full never target the same bank in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + 4'd1;
        if (beat_cnt == 4'(TILE_N - 1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end else if (bus.in_valid) begin
        overflow <= 1'b1;
      end
      if (drain) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      bank_mem[wr_bank][beat_cnt] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_tile_buffer_in.sv
// Bench for tile_buffer_in: directed scenarios plus randomized traffic,
// checked every cycle against a two-entry tile queue model.
module tb_tile_buffer_in;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 16 * DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] beat_cnt;
  logic       overflow;

  tile_buffer_in_if #(.DATA_W(DW)) bus ();

  tile_buffer_in #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .beat_cnt (beat_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: completed tiles in arrival order (at most two), plus the partial tile.
  logic [TW-1:0] q [$];
  logic [TW-1:0] part = '0;
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          acc;
  logic          drn;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [TW-1:0] ramp(input int base);
    logic [TW-1:0] r;
    r = '0;
    for (int e = 0; e < 16; e++) r[e*DW +: DW] = DW'(base + e);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      acc = bus.in_valid && (q.size() < 2);
      drn = bus.tile_ready && (q.size() > 0);
      if (bus.in_valid && !acc) m_ovf = 1'b1;
      if (drn) void'(q.pop_front());
      if (acc) begin
        part[m_cnt*DW +: DW] = bus.mem_rdata;
        if (m_cnt == 15) begin
          q.push_back(part);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",   TW'(bus.in_ready),   TW'(q.size() < 2));
      chk("tile_valid", TW'(bus.tile_valid), TW'(q.size() > 0));
      chk("beat_cnt",   TW'(beat_cnt),       TW'(m_cnt));
      chk("overflow",   TW'(overflow),       TW'(m_ovf));
      if (q.size() > 0) chk("tile_data", bus.tile_data, q[0]);
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    bus.in_valid   = v;
    bus.mem_rdata  = d;
    bus.tile_ready = r;
    flush          = f;
    @(negedge clk);
  endtask

  initial begin
    int rp;
    bus.in_valid   = 1'b0;
    bus.mem_rdata  = '0;
    bus.tile_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",   TW'(bus.in_ready),   TW'(1));
    chk("rst_tile_valid", TW'(bus.tile_valid), TW'(0));
    chk("rst_beat_cnt",   TW'(beat_cnt),       TW'(0));
    chk("rst_overflow",   TW'(overflow),       TW'(0));
    rst = 1'b0;

    // One tile 0..15, consumer stalled
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("s1_valid_before_last", TW'(bus.tile_valid), TW'(0));
      cyc(1'b1, DW'(k), 1'b0, 1'b0);
    end
    chk("s1_valid", TW'(bus.tile_valid), TW'(1));
    chk("s1_data",  bus.tile_data,       ramp(0));
    chk("s1_cnt",   TW'(beat_cnt),       TW'(0));
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("s1_flush_valid", TW'(bus.tile_valid), TW'(0));

    // 48 beats, consumer stalled: both banks fill, last 16 dropped
    for (int k = 0; k < 48; k++) begin
      cyc(1'b1, DW'(k), 1'b0, 1'b0);
      if (k == 31) begin
        chk("s2_ready_after_31", TW'(bus.in_ready), TW'(0));
        chk("s2_ovf_after_31",   TW'(overflow),     TW'(0));
      end
    end
    chk("s2_ovf",  TW'(overflow), TW'(1));
    chk("s2_cnt",  TW'(beat_cnt), TW'(0));
    chk("s2_data", bus.tile_data, ramp(0));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("s2_data_after_drain", bus.tile_data,       ramp(16));
    chk("s2_ready_freed",      TW'(bus.in_ready),   TW'(1));
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Streaming with consumer always ready
    for (int k = 0; k < 64; k++) begin
      cyc(1'b1, DW'(k), 1'b1, 1'b0);
      chk("s3_ready", TW'(bus.in_ready), TW'(1));
      if (k == 15) chk("s3_tile0", bus.tile_data, ramp(0));
      if (k == 31) chk("s3_tile1", bus.tile_data, ramp(16));
      if (k == 47) chk("s3_tile2", bus.tile_data, ramp(32));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Bank 1 completes in the cycle bank 0 drains
    for (int k = 0; k < 16; k++) cyc(1'b1, DW'(k), 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) cyc(1'b1, DW'(8'h30 + k), 1'b0, 1'b0);
    cyc(1'b1, 8'h3F, 1'b1, 1'b0);
    chk("s4_valid", TW'(bus.tile_valid), TW'(1));
    chk("s4_ready", TW'(bus.in_ready),   TW'(1));
    chk("s4_data",  bus.tile_data,       ramp(8'h30));
    chk("s4_cnt",   TW'(beat_cnt),       TW'(0));
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("s4_next_cnt", TW'(beat_cnt), TW'(1));
    chk("s4_next_ovf", TW'(overflow), TW'(0));
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Flush mid-tile (with a simultaneous beat), then a clean tile
    for (int k = 0; k < 8; k++) cyc(1'b1, DW'(k), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("s5_cnt_after_flush", TW'(beat_cnt), TW'(0));
    for (int k = 0; k < 16; k++) cyc(1'b1, DW'(8'hA0 + k), 1'b0, 1'b0);
    chk("s5_data",  bus.tile_data,       ramp(8'hA0));
    chk("s5_ovf",   TW'(overflow),       TW'(0));
    chk("s5_valid", TW'(bus.tile_valid), TW'(1));
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset mid-tile with overflow set
    for (int k = 0; k < 33; k++) cyc(1'b1, DW'(k), 1'b0, 1'b0);
    chk("s6_ovf_set", TW'(overflow), TW'(1));
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, DW'(8'hC0 + k), 1'b0, 1'b0);
    chk("s6_cnt_mid", TW'(beat_cnt), TW'(5));
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("s6_async_ready", TW'(bus.in_ready),   TW'(1));
    chk("s6_async_valid", TW'(bus.tile_valid), TW'(0));
    chk("s6_async_cnt",   TW'(beat_cnt),       TW'(0));
    chk("s6_async_ovf",   TW'(overflow),       TW'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) cyc(1'b1, DW'(8'h50 + k), 1'b0, 1'b0);
    chk("s6_data",  bus.tile_data,     ramp(8'h50));
    chk("s6_ready", TW'(bus.in_ready), TW'(1));
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with varying consumer pressure
    rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rp = $urandom_range(0, 100);
      cyc($urandom_range(0, 3) != 0, DW'($urandom),
          $urandom_range(0, 99) < rp, $urandom_range(0, 127) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tile_buffer_in.md
TILE_BUFFER_IN -- requirements
Module: tile_buffer_in

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of one input-buffer word.
REQ-002 SHALL have parameter TILE_N, fixed at 16 beats per tile (4 rows x 4 columns); it is not overridable.
REQ-003 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous clear of all tile state.
REQ-006 SHALL have port in_valid, input, 1 bit: mem_rdata carries one beat this cycle.
REQ-007 SHALL have port mem_rdata, input, DATA_W bits: input-buffer read data, in generator order (column fastest, then row).
REQ-008 SHALL have port in_ready, output, 1 bit: the current write bank can accept a beat.
REQ-009 SHALL have port tile_valid, output, 1 bit: the read bank holds a complete tile.
REQ-010 SHALL have port tile_ready, input, 1 bit: the consumer accepts the tile.
REQ-011 SHALL have port tile_data, output, 16*DATA_W bits: the read-bank tile; element e occupies bits [e*DATA_W +: DATA_W].
REQ-012 SHALL have port beat_cnt, output, 4 bits: the beat index within the tile being filled.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a beat is dropped.

Function
REQ-014 SHALL implement two tile banks (ping-pong), each 16 x DATA_W, with one full flag per bank.
REQ-015 SHALL keep a 1-bit write pointer wr_bank, a 1-bit read pointer rd_bank and a 4-bit beat counter.
REQ-016 SHALL drive in_ready = NOT full[wr_bank], combinationally.
REQ-017 SHALL, on in_valid AND in_ready, write mem_rdata to element beat_cnt of bank wr_bank and then increment beat_cnt.
REQ-018 SHALL map beat n to row n[3:2] and column n[1:0], so element index = n.
REQ-019 SHALL, on the accepted beat with beat_cnt = 15, set full[wr_bank], toggle wr_bank and wrap beat_cnt to 0 in the same edge.
REQ-020 SHALL drive tile_valid = full[rd_bank] and tile_data = bank[rd_bank], combinationally, with zero added latency.
REQ-021 SHALL, on tile_valid AND tile_ready, clear full[rd_bank] and toggle rd_bank.
REQ-022 SHALL handle completion of one bank and drain of the other bank in the same cycle independently, with both taking effect.
REQ-023 SHALL make a bank freed by a drain writable from the next cycle; there is no same-cycle bypass from tile_ready to in_ready.
REQ-024 SHALL, on in_valid with in_ready = 0, discard the beat, set overflow, and leave beat_cnt unchanged.
REQ-025 SHALL clear overflow only on rst or flush.
REQ-026 SHALL hold tile_data stable while tile_valid = 1 and tile_ready = 0.
REQ-027 SHALL, on flush, clear both full flags, wr_bank, rd_bank, beat_cnt and overflow; flush has priority over any beat or drain in the same cycle.
REQ-028 SHALL, on flush or rst in the middle of a tile, discard the partial tile and start the next beat at element 0 of bank 0.
REQ-029 SHALL give throughput of one beat per cycle sustained, with no bubble between tiles while the other bank is free.

Reset
REQ-030 SHALL, while rst = 1, asynchronously force beat_cnt = 0, wr_bank = 0, rd_bank = 0, both full flags = 0 and overflow = 0.
REQ-031 SHALL, therefore, output in_ready = 1 and tile_valid = 0 during and after reset.
REQ-032 SHALL leave bank storage contents unreset; tile_data is don't-care while tile_valid = 0.

Verification
REQ-033 SHALL cover this scenario: 16 beats with data 0..15, tile_ready = 0 -> tile_valid rises on the cycle after beat 15, and tile_data element e = e.
REQ-034 SHALL cover this scenario: 48 consecutive beats, tile_ready = 0 -> both banks fill, in_ready falls after beat 31, beats 32..47 are dropped, overflow = 1 and beat_cnt stays 0.
REQ-035 SHALL cover this scenario: continuous beats with tile_ready = 1 -> in_ready never falls, tiles emerge every 16 cycles, and tile k element e = 16k + e.
REQ-036 SHALL cover this scenario: beat 15 of bank 1 arrives in the same cycle bank 0 is drained -> full = {1,0}, rd_bank = 1, wr_bank = 0.
REQ-037 SHALL cover this scenario: flush after beat 7, then 16 beats 0xA0..0xAF -> the tile equals 0xA0..0xAF and overflow = 0.
REQ-038 SHALL cover this scenario: rst asserted asynchronously mid-tile -> outputs reach their reset values before the next clock edge, and the next tile lands in bank 0 at element 0.
